// File: rtl/parity_fifo.sv
`default_nettype none
// ============================================================================
// Module   : parity_fifo
// Brief    : Show-ahead synchronous FIFO with a parity check on the head
//            entry. A corrupt head is either discarded internally (DROP_MODE=1)
//            or delivered with an error flag (DROP_MODE=0), and every corrupt
//            entry that leaves the FIFO is counted in a saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module parity_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int EVEN_ODD      = 0,
  parameter int PARITY_BIT    = 0,
  parameter int DROP_MODE     = 1,
  parameter int AF_THRESH     = FIFO_DEPTH - 1,
  parameter int AE_THRESH     = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH:0]               push_data_i,
  input  logic                              push_valid_i,
  output logic                              push_grant_o,
  input  logic                              pop_grant_i,
  output logic [DATA_WIDTH:0]               pop_data_o,
  output logic                              pop_valid_o,
  output logic                              pop_err_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
  output logic                              almost_full_o,
  output logic                              almost_empty_o,
  output logic                              overflow_o,
  output logic                              underflow_o,
  output logic [ERR_CNT_WIDTH-1:0]          err_count_o,
  input  logic                              err_clr_i
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [c_PTR_W-1:0]       c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);
  localparam logic [c_CNT_W-1:0]       c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0]       c_AF       = c_CNT_W'(AF_THRESH);
  localparam logic [c_CNT_W-1:0]       c_AE       = c_CNT_W'(AE_THRESH);
  localparam logic                     c_ODD      = (EVEN_ODD != 0);
  localparam logic                     c_DROP     = (DROP_MODE != 0);
  localparam logic [ERR_CNT_WIDTH-1:0] c_ERR_MAX  = '1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH:0]      r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]       r_wr_ptr;
  logic [c_PTR_W-1:0]       r_rd_ptr;
  logic [c_CNT_W-1:0]       r_count;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
  logic                     r_overflow;
  logic                     r_underflow;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH:0] w_head;
  logic                w_empty;
  logic                w_full;
  logic                w_head_bad;   // head present and fails parity
  logic                w_pop_valid;
  logic                w_push;       // entry written this cycle
  logic                w_pop;        // entry taken by the consumer
  logic                w_drop;       // corrupt entry discarded internally
  logic                w_deq;        // head leaves the FIFO by either route
  logic                w_err_inc;

  // Pointer advance that wraps at the last entry, so non power-of-2 depths
  // never address past the end of the storage array.
  function automatic logic [c_PTR_W-1:0] f_ptr_next(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_head  = r_mem[r_rd_ptr];
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_DEPTH);

  // The parity checker only exists when checking is enabled; otherwise every
  // entry is treated as good and the drop/flag paths collapse to constants.
  generate
    if (PARITY_BIT != 0) begin : g_parity_chk
      assign w_head_bad = !w_empty && ((^w_head) != c_ODD);
    end else begin : g_parity_off
      assign w_head_bad = 1'b0;
    end
  endgenerate

  // A corrupt head is hidden from the consumer in drop mode and dequeued on
  // its own the next edge; in flag mode it is shown with pop_err_o set.
  assign w_pop_valid = !w_empty && !(c_DROP && w_head_bad);
  assign w_drop      = c_DROP && w_head_bad;
  assign w_pop       = pop_grant_i && w_pop_valid;
  assign w_deq       = w_pop || w_drop;

  // Grant depends only on registered occupancy: a full FIFO refuses a push
  // even when the head is leaving in the same cycle.
  assign w_push      = push_valid_i && !w_full;

  // Every corrupt entry is counted once, at the edge where it leaves.
  assign w_err_inc   = w_deq && w_head_bad;

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Storage write; not reset, and suppressed on a reset edge.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= push_data_i;
    end
  end

  // Write and read pointers, each advancing on its own operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_ptr_next(r_wr_ptr);
      end
      if (w_deq) begin
        r_rd_ptr <= f_ptr_next(r_rd_ptr);
      end
    end
  end

  // Occupancy: a simultaneous enqueue and dequeue leaves it unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_push && !w_deq) begin
      r_count <= r_count + 1'b1;
    end else if (!w_push && w_deq) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Saturating error counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_clr_i) begin
      r_err_cnt <= '0;
    end else if (w_err_inc && (r_err_cnt != c_ERR_MAX)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  // Overflow/underflow pulses are registered so they are glitch-free and
  // read 0 right after reset; each appears the cycle after the bad attempt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= push_valid_i && w_full;
      r_underflow <= pop_grant_i && w_empty;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign push_grant_o   = !w_full;
  assign pop_data_o     = w_head;
  assign pop_valid_o    = w_pop_valid;
  assign pop_err_o      = !c_DROP && w_head_bad;
  assign count_o        = r_count;
  assign almost_full_o  = (r_count >= c_AF);
  assign almost_empty_o = (r_count <= c_AE);
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;
  assign err_count_o    = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/parity_fifo.md
PARITY_FIFO -- requirements
Module: parity_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: payload width; the stored word is DATA_WIDTH+1 bits, and bit DATA_WIDTH is the parity bit.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: number of entries, any value >= 2 (power of 2 not required).
REQ-003 SHALL have parameter EVEN_ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-004 SHALL have parameter PARITY_BIT, default 0: 0 = parity check disabled (all entries good), 1 = enabled.
REQ-005 SHALL have parameter DROP_MODE, default 1: 1 = corrupt head discarded internally, 0 = corrupt head delivered and flagged.
REQ-006 SHALL have parameters AF_THRESH (default FIFO_DEPTH-1) and AE_THRESH (default 1) for the almost-full and almost-empty flags.
REQ-007 SHALL have parameter ERR_CNT_WIDTH, default 8: width of the error counter.
REQ-008 SHALL have ports as follows (clock and reset first):
- clk  in  1: single clock, rising edge.
- rst_n  in  1: synchronous reset, active-low.
- push_data_i  in  DATA_WIDTH+1: write word (payload plus parity bit).
- push_valid_i  in  1: producer has data.
- push_grant_o  out  1: FIFO can accept.
- pop_grant_i  in  1: consumer takes data.
- pop_data_o  out  DATA_WIDTH+1: head word.
- pop_valid_o  out  1: head word available.
- pop_err_o  out  1: head word has a parity error (DROP_MODE=0 only).
- count_o  out  $clog2(FIFO_DEPTH+1): current occupancy.
- almost_full_o  out  1: count_o >= AF_THRESH.
- almost_empty_o  out  1: count_o <= AE_THRESH.
- overflow_o  out  1: one-cycle pulse on a push attempt while full.
- underflow_o  out  1: one-cycle pulse on a pop attempt while empty.
- err_count_o  out  ERR_CNT_WIDTH: saturating count of corrupt entries.
- err_clr_i  in  1: clears err_count_o.

Function
REQ-009 Push SHALL occur at a rising clk edge when push_valid_i=1 and push_grant_o=1; push_grant_o SHALL be 1 exactly when count_o < FIFO_DEPTH.
REQ-010 Pop SHALL occur at a rising clk edge when pop_grant_i=1 and pop_valid_o=1.
REQ-011 pop_data_o SHALL present the head entry combinationally (show-ahead); a word pushed at edge N SHALL be visible at the output after edge N, with no empty-to-output bypass.
REQ-012 The parity check SHALL compute the XOR of all DATA_WIDTH+1 head bits; the head is good when the XOR equals EVEN_ODD, otherwise it is corrupt.
REQ-013 When DROP_MODE=1 and the head is corrupt, pop_valid_o SHALL be 0 and the entry SHALL be discarded at the next edge regardless of pop_grant_i; this is one drop per cycle, and err_count_o increments.
REQ-014 When DROP_MODE=0 and the head is corrupt, pop_valid_o SHALL be 1 and pop_err_o SHALL be 1; err_count_o SHALL increment when that entry is popped.
REQ-015 A simultaneous push and pop (or push and drop) SHALL leave count_o unchanged, and both operations SHALL complete.
REQ-016 When full, push_grant_o SHALL be 0 even if a pop or drop occurs in the same cycle (no full-bypass).
REQ-017 Read and write pointers SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-018 overflow_o SHALL pulse for one cycle when push_valid_i=1 and count_o=FIFO_DEPTH; underflow_o SHALL pulse for one cycle when pop_grant_i=1 and count_o=0. Neither event SHALL change state.
REQ-019 err_count_o SHALL saturate at its all-ones value; err_clr_i SHALL clear it to 0, taking priority over a same-cycle increment.
REQ-020 count_o, almost_full_o and almost_empty_o SHALL be decoded from registered state, with no combinational path from the handshake inputs.

Reset
REQ-021 With rst_n=0 at a rising edge, the following SHALL be true after that edge:
- pointers = 0, count_o = 0, err_count_o = 0
- pop_valid_o = 0, pop_err_o = 0
- push_grant_o = 1
- almost_full_o = 0, almost_empty_o = 1
- overflow_o = 0, underflow_o = 0
REQ-022 Memory contents SHALL NOT be required to clear on reset, and pop_data_o is don't-care while pop_valid_o=0.
REQ-023 Reset asserted mid-operation SHALL abandon all stored entries, and no push or pop SHALL occur on the reset edge.

Verification (DATA_WIDTH=32, FIFO_DEPTH=4, EVEN_ODD=0, PARITY_BIT=1)
REQ-024 Hold push_valid_i for 6 cycles with good words W0..W5: W0..W3 are accepted; push_grant_o drops after the 4th edge; count_o=4; almost_full_o=1; overflow_o pulses twice.
REQ-025 Then hold pop_grant_i for 6 cycles: W0..W3 are returned in order; count_o=0; almost_empty_o=1; underflow_o pulses twice.
REQ-026 With DROP_MODE=1, push A(good), B(bad parity), C(good), then pop: A is delivered, then one cycle with pop_valid_o=0, then C is delivered; err_count_o=1.
REQ-027 With DROP_MODE=0, push the same sequence A, B, C: A, B, C are all delivered, pop_err_o=1 only while B is at the head, and err_count_o=1 after B is popped.
REQ-028 Starting at count_o=2, run 12 cycles of simultaneous push and pop: count_o stays 2, pointers wrap 3 times, and order is preserved.
REQ-029 At count_o=3 with err_count_o=5, drive rst_n=0 for one edge: the next cycle shows count_o=0, pop_valid_o=0, push_grant_o=1, err_count_o=0, and a subsequent push is read back correctly.
